fork_2: RTL and testbench
=========================

// Module: fork_2
// PURPOSE
// - Stream splitter for the FM datapath: pops one signed sample from an input FIFO and pushes it to two output FIFOs (A, B).
// - Transmit-side counterpart of the two-input combiners: one input stream feeds two consumer branches.
// - Each branch has its own back-pressure. Each sample is delivered exactly once to each branch, in order.
// - Counts samples per frame and pulses frame_done at each frame boundary.
// PARAMETERS
// - DATA_WIDTH     8    sample width; signed two's complement
// - AUDIO_SAMPLES  10   samples per frame; must be >= 1
// - CNT_WIDTH      $clog2(AUDIO_SAMPLES+1)   width of sample_cnt
// PORTS
// - clock       in   1            single clock; all logic on posedge
// - reset       in   1            synchronous, active-low reset (sampled on posedge clock)
// - din         in   DATA_WIDTH   input FIFO read data
// - in_empty    in   1            input FIFO empty
// - in_rd_en    out  1            input FIFO pop
// - a_dout      out  DATA_WIDTH   branch A write data
// - a_full      in   1            branch A FIFO full
// - a_wr_en     out  1            branch A push
// - b_dout      out  DATA_WIDTH   branch B write data
// - b_full      in   1            branch B FIFO full
// - b_wr_en     out  1            branch B push
// - sample_cnt  out  CNT_WIDTH    samples fully delivered in the current frame
// - frame_done  out  1            1-cycle pulse when the last sample of a frame completes on both branches
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE; hold register, done_a/done_b and sample_cnt cleared.
//   - All outputs are 0 during reset and in the cycle that follows it.
//   - A sample captured but not fully delivered is dropped.
// - Input FIFO timing: data is valid on din in the cycle after in_rd_en.
// - FSM has three states:
//   - IDLE: if !in_empty, assert in_rd_en for one cycle and go to CAPTURE; otherwise stay.
//   - CAPTURE: hold <= din; done_a <= 0; done_b <= 0; go to WRITE. No handshakes asserted.
//   - WRITE, branch A: if !done_a && !a_full, a_wr_en=1 and done_a <= 1.
//   - WRITE, branch B: same rule, independently, using done_b and b_full.
//   - Both branches may push in the same cycle.
//   - WRITE exit: when both branches are done (including pushes made this cycle), increment the count and go to IDLE.
// - dout rules: a_dout/b_dout are driven from hold only while the matching wr_en is 1; otherwise 0 (combinational).
// - Throughput: 3 cycles per sample with no back-pressure. No pop occurs while a sample is pending.
// - Count and frame_done:
//   - sample_cnt increments on completion of each sample.
//   - When the completed sample is number AUDIO_SAMPLES, frame_done=1 that cycle and sample_cnt wraps to 0.
//   - No special case is needed for AUDIO_SAMPLES=1: frame_done pulses on every sample.
// - Boundary conditions:
//   - A full for N cycles stalls only A: B may complete first, and WRITE holds until A drains. No duplicate pushes.
//   - Both branches full: wait indefinitely with no side effects.
//   - in_empty is ignored outside IDLE.
//   - in_rd_en is never asserted when in_empty=1.
// CONFIGURATION
// - FORK_NEGATE_B_EN defined: b_dout = -hold, saturating.
//   - The most-negative value -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1)-1.
//   - Branch A is unchanged. This produces the difference-path sign flip.
// - FORK_NEGATE_B_EN undefined: b_dout = hold, bit-exact with a_dout.
// - Timing is identical in both builds.
// STRUCTURE
// - Shared package fm_pkg:
//   - fork_state_t enum {IDLE, CAPTURE, WRITE}
//   - sat_neg function, used by FORK_NEGATE_B_EN
// - Single module, no sub-modules. The FSM uses a registered state plus a combinational next-state block.
// TESTING
// - Stream 0x05, 0x80, 0x7F with both branches free -> A and B each receive 0x05, 0x80, 0x7F in order, 3 cycles per sample.
// - a_full=1 for 5 cycles on the first sample -> B pushes once immediately; A pushes once after release; exactly one push per branch.
// - DATA_WIDTH=8 with FORK_NEGATE_B_EN, input 0x80 then 0x03 -> B gets 0x7F, 0xFD; A gets 0x80, 0x03.
// - AUDIO_SAMPLES=10, 25 samples -> frame_done pulses after samples 10 and 20; sample_cnt=5 at the end.
// - Assert reset (reset=0) in WRITE with B done and A full -> next cycle all outputs 0, sample_cnt=0, state IDLE, the sample is not replayed.
// - in_empty=1 throughout -> in_rd_en, a_wr_en and b_wr_en never assert.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared definitions for the FM datapath: fork FSM state encoding and
// the saturating negation used on the difference path.
package fm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2
    } fork_state_t;

    // Negate a w-bit signed value (sign-extended to 64 bits); the most-negative
    // code has no positive twin, so it clamps to the largest positive code.
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] v,
                                                   input int unsigned      w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v < -hi)
            return hi;
        return -v;
    endfunction

endpackage

// File: rtl/fork_2.sv
// Stream splitter: pops one signed sample and delivers it once to each of two
// back-pressured branches. Define FORK_NEGATE_B_EN to send the saturated negation to branch B.
module fork_2
    import fm_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int AUDIO_SAMPLES = 10,
    parameter int CNT_WIDTH     = $clog2(AUDIO_SAMPLES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] a_dout,
    input  logic                         a_full,
    output logic                         a_wr_en,
    output logic signed [DATA_WIDTH-1:0] b_dout,
    input  logic                         b_full,
    output logic                         b_wr_en,
    output logic        [CNT_WIDTH-1:0]  sample_cnt,
    output logic                         frame_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(AUDIO_SAMPLES - 1);

    fork_state_t                  state;
    fork_state_t                  next_state;
    logic signed [DATA_WIDTH-1:0] hold;
    logic signed [DATA_WIDTH-1:0] b_val;
    logic                         done_a;
    logic                         done_b;
    logic                         armed;
    logic                         complete;

    // armed stays low for the first cycle after reset so no pop happens there
    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_rd_en) next_state = CAPTURE;
            CAPTURE: next_state = WRITE;
            WRITE:   if (complete) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_rd_en   = 1'b0;
        a_wr_en    = 1'b0;
        b_wr_en    = 1'b0;
        complete   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: in_rd_en = reset && armed && !in_empty;
            WRITE: begin
                a_wr_en  = reset && !done_a && !a_full;
                b_wr_en  = reset && !done_b && !b_full;
                complete = reset && (done_a || a_wr_en) && (done_b || b_wr_en);
            end
            default: ;
        endcase
        frame_done = complete && (sample_cnt == LAST_IDX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold       <= '0;
            done_a     <= 1'b0;
            done_b     <= 1'b0;
            sample_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == CAPTURE) begin
                hold   <= din;
                done_a <= 1'b0;
                done_b <= 1'b0;
            end
            if (a_wr_en) done_a <= 1'b1;
            if (b_wr_en) done_b <= 1'b1;
            if (complete)
                sample_cnt <= frame_done ? '0 : sample_cnt + 1'b1;
        end
    end

`ifdef FORK_NEGATE_B_EN
    logic signed [63:0] neg_full;
    logic               unused_neg_hi;
    assign neg_full      = sat_neg({{(64 - DATA_WIDTH){hold[DATA_WIDTH-1]}}, hold}, DATA_WIDTH);
    assign b_val         = neg_full[DATA_WIDTH-1:0];
    assign unused_neg_hi = ^neg_full[63:DATA_WIDTH];
`else
    assign b_val = hold;
`endif

    assign a_dout = a_wr_en ? hold  : '0;
    assign b_dout = b_wr_en ? b_val : '0;

endmodule

// File: tb/tb_fork_2.sv
// Scoreboard bench for fork_2: stimulus pushes expected samples per branch,
// a negedge monitor pops and compares on every push.
module tb_fork_2;

    localparam int DW = 8;
    localparam int AS = 10;
    localparam int CW = $clog2(AS + 1);

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 in_empty;
    logic                 in_rd_en;
    logic signed [DW-1:0] a_dout;
    logic                 a_full = 1'b0;
    logic                 a_wr_en;
    logic signed [DW-1:0] b_dout;
    logic                 b_full = 1'b0;
    logic                 b_wr_en;
    logic [CW-1:0]        sample_cnt;
    logic                 frame_done;

    logic        force_empty = 1'b0;
    logic [7:0]  mem [0:255];
    int          wr_total = 0;
    int          rd_total = 0;
    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    int          a_push_cyc [$];
    int          cyc = 0;
    int          a_pushes = 0;
    int          b_pushes = 0;
    int          frames = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    fork_2 #(.DATA_WIDTH(DW), .AUDIO_SAMPLES(AS)) dut (
        .clock(clock), .reset(reset), .din(din), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .a_dout(a_dout), .a_full(a_full), .a_wr_en(a_wr_en),
        .b_dout(b_dout), .b_full(b_full), .b_wr_en(b_wr_en),
        .sample_cnt(sample_cnt), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Input FIFO model: data appears on din the cycle after the pop
    assign in_empty = force_empty || (wr_total == rd_total);
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (in_rd_en) begin
            din      <= mem[rd_total[7:0]];
            rd_total <= rd_total + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    function automatic logic [7:0] model_b(input logic [7:0] v);
`ifdef FORK_NEGATE_B_EN
        if (v == 8'h80) return 8'h7F;
        return 8'(8'h00 - v);
`else
        return v;
`endif
    endfunction

    task automatic send(input logic [7:0] v);
        mem[wr_total[7:0]] = v;
        exp_a.push_back(v);
        exp_b.push_back(model_b(v));
        wr_total++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_a.size() == 0 && exp_b.size() == 0 && wr_total == rd_total)) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget)
            chk("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_rd"},  {31'd0, in_rd_en}, 32'd0);
        chk({nm, "_awr"}, {31'd0, a_wr_en}, 32'd0);
        chk({nm, "_bwr"}, {31'd0, b_wr_en}, 32'd0);
        chk({nm, "_adout"}, 32'(a_dout), 32'd0);
        chk({nm, "_bdout"}, 32'(b_dout), 32'd0);
        chk({nm, "_cnt"}, 32'(sample_cnt), 32'd0);
        chk({nm, "_frame"}, {31'd0, frame_done}, 32'd0);
    endtask

    // Monitor: every push is matched against the scoreboard head
    always @(negedge clock) begin
        if (a_wr_en) begin
            a_pushes++;
            a_push_cyc.push_back(cyc);
            if (exp_a.size() == 0) chk("a_unexpected_push", 32'd1, 32'd0);
            else                   chk("a_data", 32'(a_dout[7:0]), 32'(exp_a.pop_front()));
        end else begin
            chk("a_dout_idle", 32'(a_dout), 32'd0);
        end
        if (b_wr_en) begin
            b_pushes++;
            if (exp_b.size() == 0) chk("b_unexpected_push", 32'd1, 32'd0);
            else                   chk("b_data", 32'(b_dout[7:0]), 32'(exp_b.pop_front()));
        end else begin
            chk("b_dout_idle", 32'(b_dout), 32'd0);
        end
        if (in_rd_en)
            chk("rd_while_empty", {31'd0, in_empty}, 32'd0);
        if (frame_done) begin
            frames++;
            chk("frame_at_cnt", 32'(sample_cnt), 32'(AS - 1));
        end
    end

    initial begin
        int a0, b0, r0, f0;

        // Reset with a sample already waiting; no pop in the first cycle after release
        send(8'h11);
        repeat (2) @(negedge clock);
        chk_quiet("in_reset");
        reset = 1'b1;
        #1;
        chk_quiet("post_reset");
        @(negedge clock);
        chk("first_pop", {31'd0, in_rd_en}, 32'd1);
        drain(50);

        // Free-flowing stream, 3 cycles per sample
        a_push_cyc.delete();
        send(8'h05); send(8'h80); send(8'h7F);
        drain(50);
        chk("stream_pushes", 32'(a_push_cyc.size()), 32'd3);
        if (a_push_cyc.size() == 3) begin
            chk("gap1", 32'(a_push_cyc[1] - a_push_cyc[0]), 32'd3);
            chk("gap2", 32'(a_push_cyc[2] - a_push_cyc[1]), 32'd3);
        end

        // A held full: B completes first, A once after release
        a0 = a_pushes; b0 = b_pushes;
        a_full = 1'b1;
        send(8'h22);
        repeat (5) @(negedge clock);
        chk("stall_a_cnt", 32'(a_pushes - a0), 32'd0);
        chk("stall_b_cnt", 32'(b_pushes - b0), 32'd1);
        a_full = 1'b0;
        drain(50);
        chk("release_a_cnt", 32'(a_pushes - a0), 32'd1);
        chk("release_b_cnt", 32'(b_pushes - b0), 32'd1);

        // Both full: nothing moves
        a0 = a_pushes; b0 = b_pushes;
        a_full = 1'b1; b_full = 1'b1;
        send(8'hC3);
        repeat (8) @(negedge clock);
        chk("both_full_a", 32'(a_pushes - a0), 32'd0);
        chk("both_full_b", 32'(b_pushes - b0), 32'd0);
        a_full = 1'b0; b_full = 1'b0;
        drain(50);

        // Sign-flip vectors (B equals A in the default build)
        send(8'h80); send(8'h03);
        drain(50);

        // Reset mid-WRITE with B done and A full: sample dropped, not replayed
        a0 = a_pushes; b0 = b_pushes;
        a_full = 1'b1;
        send(8'h44);
        repeat (4) @(negedge clock);
        chk("pre_reset_b", 32'(b_pushes - b0), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk_quiet("mid_reset");
        exp_a.delete();
        a_full = 1'b0;
        reset = 1'b1;
        #1;
        chk_quiet("after_mid_reset");
        repeat (10) @(negedge clock);
        chk("no_replay_a", 32'(a_pushes - a0), 32'd0);
        chk("no_replay_b", 32'(b_pushes - b0), 32'd1);

        // 25 samples: frames after 10 and 20, count ends at 5
        f0 = frames;
        for (int i = 0; i < 25; i++)
            send(8'(i * 7 + 1));
        drain(300);
        chk("frames", 32'(frames - f0), 32'd2);
        chk("final_cnt", 32'(sample_cnt), 32'd5);

        // Empty input: no handshakes at all
        a0 = a_pushes; b0 = b_pushes; r0 = rd_total;
        repeat (20) @(negedge clock);
        chk("empty_rd", 32'(rd_total - r0), 32'd0);
        chk("empty_a", 32'(a_pushes - a0), 32'd0);
        chk("empty_b", 32'(b_pushes - b0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
